cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 164 ++++++++++++++++
 tb/tb_cache_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin arbiter that gives two requesters shared access to a
// single-ported cache, with a BUSY-cycle timeout and saturating access statistics.
module cache_arbiter #(
  parameter int ADDR_W  = 15,
  parameter int CNT_W   = 14,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_done,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_done,
  output logic              hit,
  output logic              err,
  output logic              cache_read,
  output logic              cache_write,
  output logic [ADDR_W-1:0] address,
  input  logic              cache_ready,
  input  logic              cache_hit,
  input  logic              clear_stats,
  output logic [CNT_W-1:0]  req0_count,
  output logic [CNT_W-1:0]  req1_count,
  output logic [CNT_W-1:0]  hit_count
);

  // The BUSY counter only ever holds 0..TIMEOUT-1; the abort fires on its last value.
  localparam int              TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   LAST_BUSY = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              hit_q, hit_d;
  logic              err_q, err_d;
  logic [TW-1:0]     busy_cnt_q, busy_cnt_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;

  logic elig0;
  logic elig1;
  logic grant;
  logic count;

  // A requester still showing its done pulse is not eligible, so a held valid cannot reissue.
  assign elig0 = req0_valid && !done0_q;
  assign elig1 = req1_valid && !done1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      hit_q        <= 1'b0;
      err_q        <= 1'b0;
      busy_cnt_q   <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
      hit_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      hit_q        <= hit_d;
      err_q        <= err_d;
      busy_cnt_q   <= busy_cnt_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      hit_cnt_q    <= hit_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    hit_d        = 1'b0;
    err_d        = 1'b0;
    busy_cnt_d   = busy_cnt_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    hit_cnt_d    = hit_cnt_q;
    grant        = 1'b0;
    count        = 1'b0;

    if (state_q == IDLE) begin
      if (elig0 || elig1) begin
        grant      = (elig0 && elig1) ? ~last_grant_q : elig1;
        state_d    = BUSY;
        owner_d    = grant;
        busy_cnt_d = '0;
        addr_d     = grant ? req1_addr : req0_addr;
        wr_d       = grant ? req1_write : req0_write;
        rd_d       = grant ? ~req1_write : ~req0_write;
      end
    end else if (cache_ready || (busy_cnt_q == LAST_BUSY)) begin
      // A cache_ready arriving on the final allowed cycle still counts as a normal completion.
      state_d      = IDLE;
      rd_d         = 1'b0;
      wr_d         = 1'b0;
      last_grant_d = owner_q;
      done0_d      = ~owner_q;
      done1_d      = owner_q;
      hit_d        = cache_ready && cache_hit;
      err_d        = ~cache_ready;
      count        = cache_ready;
    end else begin
      busy_cnt_d = busy_cnt_q + 1'b1;
    end

    if (clear_stats) begin
      cnt0_d    = '0;
      cnt1_d    = '0;
      hit_cnt_d = '0;
    end else if (count) begin
      if (!owner_q && (cnt0_q != CNT_MAX)) cnt0_d = cnt0_q + 1'b1;
      if (owner_q && (cnt1_q != CNT_MAX)) cnt1_d = cnt1_q + 1'b1;
      if (cache_hit && (hit_cnt_q != CNT_MAX)) hit_cnt_d = hit_cnt_q + 1'b1;
    end
  end

  assign req0_done   = done0_q;
  assign req1_done   = done1_q;
  assign hit         = hit_q;
  assign err         = err_q;
  assign cache_read  = rd_q;
  assign cache_write = wr_q;
  assign address     = addr_q;
  assign req0_count  = cnt0_q;
  assign req1_count  = cnt1_q;
  assign hit_count   = hit_cnt_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: randomized scoreboard bench for cache_arbiter; a transaction-level
// model predicts each completion and a monitor compares it when the DUT pulses done.
module tb_cache_arbiter;

  localparam int AW   = 15;
  localparam int CW   = 2;
  localparam int TO   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0;
  logic          req0_write = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic          req0_done;
  logic          req1_valid = 1'b0;
  logic          req1_write = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic          req1_done;
  logic          hit;
  logic          err;
  logic          cache_read;
  logic          cache_write;
  logic [AW-1:0] address;
  logic          cache_ready = 1'b0;
  logic          cache_hit = 1'b0;
  logic          clear_stats = 1'b0;
  logic [CW-1:0] req0_count;
  logic [CW-1:0] req1_count;
  logic [CW-1:0] hit_count;

  always #5 clk = ~clk;

  cache_arbiter #(
    .ADDR_W (AW),
    .CNT_W  (CW),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_write (req0_write),
    .req0_addr  (req0_addr),
    .req0_done  (req0_done),
    .req1_valid (req1_valid),
    .req1_write (req1_write),
    .req1_addr  (req1_addr),
    .req1_done  (req1_done),
    .hit        (hit),
    .err        (err),
    .cache_read (cache_read),
    .cache_write(cache_write),
    .address    (address),
    .cache_ready(cache_ready),
    .cache_hit  (cache_hit),
    .clear_stats(clear_stats),
    .req0_count (req0_count),
    .req1_count (req1_count),
    .hit_count  (hit_count)
  );

  typedef struct {
    int owner;
    int write;
    int addr;
    int hit;
    int err;
    int cmdCycles;
    int doneCycle;
    int c0;
    int c1;
    int ch;
  } exp_t;

  exp_t expQ[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Requester agents: an outstanding request is held until its done pulse
  bit            pend[2];
  bit            wrReq[2];
  logic [AW-1:0] adReq[2];

  // Transaction-level reference: who owns the cache, for how long, and the statistics
  bit            mBusy = 1'b0;
  int            mOwner = 0;
  int            mK = 0;
  int            mRdyAt = 0;
  int            mLast = 1;
  int            mDoneOwner = -1;
  bit            mHit = 1'b0;
  bit            mWr = 1'b0;
  logic [AW-1:0] mAddr = '0;
  int            mCnt[2];
  int            mHitCnt = 0;

  int pReq = 0;
  int fixLat = 0;
  int fixHit = -1;
  int pClear = 0;
  bit clrOnDone = 1'b0;
  bit altMode = 1'b0;
  int prevOwner = -1;

  int            cmdCnt = 0;
  logic [AW-1:0] cmdAddr = '0;
  logic          cmdWr = 1'b0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive requesters and the cache, then advance the reference
  task automatic applyStimulus(input bit doReset);
    bit   v[2];
    bit   el[2];
    bit   cmpl;
    bit   normal;
    int   w;
    int   nextDone;
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    for (int n = 0; n < 2; n++) begin
      if (mDoneOwner == n) begin
        v[n]    = 1'b1;
        pend[n] = 1'b0;
      end else begin
        if (!pend[n] && ($urandom_range(0, 99) < pReq)) begin
          pend[n]  = 1'b1;
          wrReq[n] = 1'($urandom_range(0, 1));
          adReq[n] = AW'($urandom);
        end
        v[n] = pend[n];
      end
      el[n] = v[n] && !mBusy && (mDoneOwner != n);
    end
    req0_valid = v[0];
    req0_write = wrReq[0];
    req0_addr  = adReq[0];
    req1_valid = v[1];
    req1_write = wrReq[1];
    req1_addr  = adReq[1];
    rst        = doReset;

    cmpl   = mBusy && ((mK == mRdyAt) || (mK == TO));
    normal = mBusy && (mK == mRdyAt);
    cache_ready = normal ? 1'b1 : (!mBusy && ($urandom_range(0, 3) == 0));
    cache_hit   = normal ? mHit : 1'($urandom_range(0, 1));
    clear_stats = ($urandom_range(0, 99) < pClear) || (clrOnDone && normal);

    nextDone = -1;
    if (doReset) begin
      mBusy   = 1'b0;
      mLast   = 1;
      mCnt[0] = 0;
      mCnt[1] = 0;
      mHitCnt = 0;
    end else begin
      if (clear_stats) begin
        mCnt[0] = 0;
        mCnt[1] = 0;
        mHitCnt = 0;
      end else if (normal) begin
        if (mCnt[mOwner] < CMAX) mCnt[mOwner]++;
        if (mHit && (mHitCnt < CMAX)) mHitCnt++;
      end
      if (cmpl) begin
        e.owner     = mOwner;
        e.write     = int'(mWr);
        e.addr      = int'(mAddr);
        e.hit       = normal ? int'(mHit) : 0;
        e.err       = normal ? 0 : 1;
        e.cmdCycles = mK;
        e.doneCycle = cyc + 1;
        e.c0        = mCnt[0];
        e.c1        = mCnt[1];
        e.ch        = mHitCnt;
        expQ.push_back(e);
        mBusy    = 1'b0;
        mLast    = mOwner;
        nextDone = mOwner;
      end else if (mBusy) begin
        mK++;
      end else if (el[0] || el[1]) begin
        w      = (el[0] && el[1]) ? (1 - mLast) : (el[0] ? 0 : 1);
        mBusy  = 1'b1;
        mOwner = w;
        mWr    = wrReq[w];
        mAddr  = adReq[w];
        mK     = 1;
        mRdyAt = (fixLat > 0) ? fixLat : $urandom_range(1, TO + 1);
        mHit   = (fixHit >= 0) ? 1'(fixHit) : 1'($urandom_range(0, 1));
      end
    end
    mDoneOwner = nextDone;
  endtask

  task automatic runUntilIdle(input int maxCyc);
    int n;
    n = 0;
    do begin
      applyStimulus(1'b0);
      n++;
    end while ((mBusy || (mDoneOwner >= 0) || pend[0] || pend[1]) && (n < maxCyc));
    if (mBusy || pend[0] || pend[1]) checkOutput("run_bound", n, 0);
  endtask

  task automatic checkIdleZero();
    @(negedge clk);
    checkOutput("rst_cache_read", int'(cache_read), 0);
    checkOutput("rst_cache_write", int'(cache_write), 0);
    checkOutput("rst_address", int'(address), 0);
    checkOutput("rst_req0_done", int'(req0_done), 0);
    checkOutput("rst_req1_done", int'(req1_done), 0);
    checkOutput("rst_hit", int'(hit), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_req0_count", int'(req0_count), 0);
    checkOutput("rst_req1_count", int'(req1_count), 0);
    checkOutput("rst_hit_count", int'(hit_count), 0);
  endtask

  // Monitor: pops the scoreboard on every done pulse and checks command framing each cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    int   owner;
    if (cyc > 0) begin
      checkOutput("cmd_exclusive", int'(cache_read & cache_write), 0);
      checkOutput("done_exclusive", int'(req0_done & req1_done), 0);
      if (cache_read || cache_write) begin
        if (cmdCnt == 0) begin
          cmdAddr = address;
          cmdWr   = cache_write;
        end else begin
          checkOutput("cmd_stable", int'({cache_write, address}), int'({cmdWr, cmdAddr}));
        end
        cmdCnt++;
      end
      if (req0_done || req1_done) begin
        owner = req1_done ? 1 : 0;
        if (expQ.size() == 0) begin
          checkOutput("done_unexpected", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("done_owner", owner, e.owner);
          checkOutput("done_cycle", cyc, e.doneCycle);
          checkOutput("hit", int'(hit), e.hit);
          checkOutput("err", int'(err), e.err);
          checkOutput("cmd_cycles", cmdCnt, e.cmdCycles);
          checkOutput("cmd_addr", int'(cmdAddr), e.addr);
          checkOutput("cmd_write", int'(cmdWr), e.write);
          checkOutput("req0_count", int'(req0_count), e.c0);
          checkOutput("req1_count", int'(req1_count), e.c1);
          checkOutput("hit_count", int'(hit_count), e.ch);
          if (altMode && (prevOwner >= 0)) checkOutput("alternate", owner, 1 - prevOwner);
          prevOwner = owner;
        end
        cmdCnt = 0;
      end else begin
        checkOutput("err_without_done", int'(err), 0);
        while ((expQ.size() > 0) && (expQ[0].doneCycle < cyc)) begin
          checkOutput("done_missing", 0, 1);
          void'(expQ.pop_front());
        end
      end
      if (rst) cmdCnt = 0;
    end
  end

  initial begin
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkIdleZero();

    // Single read, hit returned on the third BUSY cycle
    pend[0]  = 1'b1;
    wrReq[0] = 1'b0;
    adReq[0] = 15'h0400;
    fixLat   = 3;
    fixHit   = 1;
    runUntilIdle(30);
    @(negedge clk);
    checkOutput("single_req0_count", int'(req0_count), 1);
    checkOutput("single_hit_count", int'(hit_count), 1);

    // Contention from reset: both held, immediate ready
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    pReq      = 100;
    fixLat    = 1;
    fixHit    = -1;
    altMode   = 1'b1;
    prevOwner = -1;
    repeat (24) applyStimulus(1'b0);
    pReq = 0;
    runUntilIdle(30);
    @(negedge clk);
    altMode = 1'b0;

    // Timeout on requester 1, then a ready landing exactly on the last allowed cycle
    pend[1]  = 1'b1;
    wrReq[1] = 1'b1;
    adReq[1] = 15'h1234;
    fixLat   = TO + 1;
    runUntilIdle(30);
    @(negedge clk);
    checkOutput("timeout_done1", int'(req1_done), 1);
    checkOutput("timeout_err", int'(err), 1);
    pend[0]  = 1'b1;
    wrReq[0] = 1'b1;
    adReq[0] = 15'h7abc;
    fixLat   = TO;
    runUntilIdle(30);
    @(negedge clk);
    checkOutput("last_cycle_ready_err", int'(err), 0);

    // Saturation of the 2-bit counters, then a clear coincident with a completion
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    fixLat = 2;
    fixHit = 1;
    repeat (5) begin
      pend[0]  = 1'b1;
      wrReq[0] = 1'b0;
      adReq[0] = AW'($urandom);
      runUntilIdle(30);
    end
    @(negedge clk);
    checkOutput("sat_req0_count", int'(req0_count), 3);
    checkOutput("sat_hit_count", int'(hit_count), 3);
    clrOnDone = 1'b1;
    pend[0]   = 1'b1;
    runUntilIdle(30);
    clrOnDone = 1'b0;
    @(negedge clk);
    checkOutput("clr_req0_count", int'(req0_count), 0);
    checkOutput("clr_req1_count", int'(req1_count), 0);
    checkOutput("clr_hit_count", int'(hit_count), 0);

    // Reset in the middle of an access by requester 1; requester 0 must win the tie after
    pend[0]  = 1'b1;
    pend[1]  = 1'b1;
    wrReq[0] = 1'b0;
    wrReq[1] = 1'b1;
    adReq[0] = 15'h0111;
    adReq[1] = 15'h0222;
    fixLat   = TO + 1;
    fixHit   = -1;
    repeat (3) applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkIdleZero();
    applyStimulus(1'b0);
    @(negedge clk);
    checkOutput("post_rst_addr", int'(address), 'h0111);
    checkOutput("post_rst_read", int'(cache_read), 1);
    fixLat = 0;
    runUntilIdle(60);

    // Random traffic with random latencies, timeouts, hits and clears
    pReq   = 35;
    pClear = 4;
    repeat (600) applyStimulus(1'b0);
    pReq   = 0;
    pClear = 0;
    runUntilIdle(60);
    repeat (3) applyStimulus(1'b0);
    @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
